// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_arb_pkg
// Brief  : Shared state encoding and slave-select codes for the SPI arbiter.
// Rev    : 1.0
// ============================================================================
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } spi_arb_state_t;

  localparam logic [2:0] SS_TRIG = 3'b000;
  localparam logic [2:0] SS_CH1  = 3'b001;
  localparam logic [2:0] SS_CH2  = 3'b010;
  localparam logic [2:0] SS_CH3  = 3'b011;
  localparam logic [2:0] SS_EEP  = 3'b100;

  localparam logic [7:0] C_TIMEOUT_BYTE = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/spi_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin select, searching upward from last+1.
// Rev    : 1.0
// ============================================================================
module rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  localparam logic [IW:0] C_NREQ = (IW+1)'(NREQ);

  logic [IW:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_cand   = '0;
    // Visit candidates last+1 .. last+NREQ (mod NREQ); the previous winner comes last.
    for (int off = 1; off <= NREQ; off++) begin
      w_cand = {1'b0, i_last} + (IW+1)'(off);
      if (w_cand >= C_NREQ) w_cand = w_cand - C_NREQ;
      if (!o_valid && i_req[w_cand[IW-1:0]]) begin
        o_valid                   = 1'b1;
        o_idx                     = w_cand[IW-1:0];
        o_onehot[w_cand[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_arb.sv
`default_nettype none
// ============================================================================
// Module : spi_arb
// Brief  : Round-robin sequencer sharing one SPI master among NREQ requesters,
//          with read-byte return and a sticky transaction watchdog.
// Rev    : 1.0
// ============================================================================
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*3-1:0] req_ss,
  input  logic [NREQ*16-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              timeout_err,
  input  logic              clr_err,
  output logic [15:0]       SPI_data,
  output logic [2:0]        ss,
  output logic              wrt_SPI,
  input  logic              SPI_done,
  input  logic [7:0]        EEP_data
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] C_WDOG_MAX = WW'(TIMEOUT);

  spi_arb_state_t r_state, w_next_state;

  logic [IW-1:0]   r_last;
  logic [WW-1:0]   r_wdog;
  logic [NREQ-1:0] r_gnt, r_done;
  logic [7:0]      r_rdata;
  logic            r_busy, r_err, r_wrt;
  logic [15:0]     r_spi_data;
  logic [2:0]      r_ss;

  logic [NREQ-1:0] w_pick_oh;
  logic [IW-1:0]   w_pick_idx;
  logic            w_pick_valid;
  logic            w_take, w_finish, w_tmo;
  logic [2:0]      w_ss   [NREQ];
  logic [15:0]     w_data [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign w_ss[i]   = req_ss[3*i +: 3];
    assign w_data[i] = req_data[16*i +: 16];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .i_req    (req),
    .i_last   (r_last),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_take       = 1'b0;
    w_finish     = 1'b0;
    w_tmo        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_take       = 1'b1;
          w_next_state = LAUNCH;
        end
      end
      LAUNCH: w_next_state = WAIT;
      WAIT: begin
        // A real completion beats the watchdog when both land together.
        if (SPI_done) begin
          w_finish     = 1'b1;
          w_next_state = IDLE;
        end else if (r_wdog == C_WDOG_MAX) begin
          w_finish     = 1'b1;
          w_tmo        = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= IW'(NREQ - 1);
      r_wdog     <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_rdata    <= 8'h00;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_wrt      <= 1'b0;
      r_spi_data <= 16'h0000;
      r_ss       <= 3'b000;
    end else begin
      r_busy <= (w_next_state != IDLE);
      r_wrt  <= (r_state == LAUNCH);
      r_done <= '0;
      if (w_take) begin
        r_gnt      <= w_pick_oh;
        r_spi_data <= w_data[w_pick_idx];
        r_ss       <= w_ss[w_pick_idx];
        r_last     <= w_pick_idx;
        r_wdog     <= '0;
      end
      if (r_state == WAIT && !w_finish) r_wdog <= r_wdog + 1'b1;
      if (w_finish) begin
        r_gnt   <= '0;
        r_done  <= r_gnt;
        r_rdata <= w_tmo ? C_TIMEOUT_BYTE : EEP_data;
      end
      if (clr_err)    r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign busy        = r_busy;
  assign timeout_err = r_err;
  assign SPI_data    = r_spi_data;
  assign ss          = r_ss;
  assign wrt_SPI     = r_wrt;

endmodule
`default_nettype wire

// File: tb/tb_spi_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_arb
// Brief  : Directed, table-driven self-checking bench for spi_arb.
// Rev    : 1.0
// ============================================================================
module tb_spi_arb;
  import spi_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int TMO  = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [5:0]  req_ss = '0;
  logic [31:0] req_data = '0;
  logic        clr_err = 1'b0;
  logic        SPI_done = 1'b0;
  logic [7:0]  EEP_data = '0;
  logic [1:0]  gnt, done;
  logic [7:0]  rdata;
  logic        busy, timeout_err, wrt_SPI;
  logic [15:0] SPI_data;
  logic [2:0]  ss;

  int n_tests = 0;
  int n_fail  = 0;

  spi_arb #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_ss(req_ss), .req_data(req_data),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .timeout_err(timeout_err),
    .clr_err(clr_err), .SPI_data(SPI_data), .ss(ss), .wrt_SPI(wrt_SPI),
    .SPI_done(SPI_done), .EEP_data(EEP_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [2:0]  ss0;
    logic [15:0] d0;
    logic [2:0]  ss1;
    logic [15:0] d1;
    logic [7:0]  eep;
    logic [1:0]  egnt;
    logic [2:0]  ess;
    logic [15:0] edata;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    req_ss   = {v.ss1, v.ss0};
    req_data = {v.d1, v.d0};
    req      = v.req;
    tick();
    chk({tag, ".gnt"}, 32'(gnt), 32'(v.egnt));
    chk({tag, ".busy"}, 32'(busy), 1);
    chk({tag, ".wrt0"}, 32'(wrt_SPI), 0);
    tick();
    chk({tag, ".wrt1"}, 32'(wrt_SPI), 1);
    chk({tag, ".ss"}, 32'(ss), 32'(v.ess));
    chk({tag, ".data"}, 32'(SPI_data), 32'(v.edata));
    SPI_done = 1'b1;
    EEP_data = v.eep;
    tick();
    SPI_done = 1'b0;
    req      = '0;
    chk({tag, ".done"}, 32'(done), 32'(v.egnt));
    chk({tag, ".rdata"}, 32'(rdata), 32'(v.eep));
    chk({tag, ".gnt_off"}, 32'(gnt), 0);
    chk({tag, ".wrt_off"}, 32'(wrt_SPI), 0);
    tick();
    chk({tag, ".done_off"}, 32'(done), 0);
    chk({tag, ".idle"}, 32'(busy), 0);
  endtask

  initial begin
    logic [1:0] exp_g;
    int         cyc;

    // Expected winners assume the pointer chain: reset(last=1) -> 0 -> 1 -> 0 -> 0 -> 1.
    vt[0] = '{2'b01, SS_CH2,  16'h1234, SS_TRIG, 16'h0000, 8'h5A, 2'b01, SS_CH2,  16'h1234};
    vt[1] = '{2'b11, SS_TRIG, 16'hAAAA, SS_EEP,  16'hBEEF, 8'hC3, 2'b10, SS_EEP,  16'hBEEF};
    vt[2] = '{2'b11, SS_TRIG, 16'hAAAA, SS_EEP,  16'hBEEF, 8'h3C, 2'b01, SS_TRIG, 16'hAAAA};
    vt[3] = '{2'b01, SS_CH3,  16'h0F0F, SS_CH1,  16'h7777, 8'h00, 2'b01, SS_CH3,  16'h0F0F};
    vt[4] = '{2'b10, SS_CH3,  16'h0F0F, SS_CH1,  16'hFFFF, 8'h81, 2'b10, SS_CH1,  16'hFFFF};
    vt[5] = '{2'b10, SS_TRIG, 16'h0000, SS_EEP,  16'h5555, 8'h77, 2'b10, SS_EEP,  16'h5555};

    repeat (3) tick();
    chk("rst.gnt", 32'(gnt), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.rdata", 32'(rdata), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.err", 32'(timeout_err), 0);
    chk("rst.data", 32'(SPI_data), 0);
    chk("rst.ss", 32'(ss), 0);
    chk("rst.wrt", 32'(wrt_SPI), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Continuous req=11 alternates grants with one IDLE clock between done and gnt.
    req_ss   = {SS_EEP, SS_CH1};
    req_data = {16'hB0B0, 16'hA0A0};
    req      = 2'b11;
    exp_g    = 2'b01;
    for (int n = 0; n < 4; n++) begin
      cyc = 0;
      while (gnt == 2'b00 && cyc < 5) begin
        tick();
        cyc++;
      end
      chk($sformatf("alt%0d.gnt", n), 32'(gnt), 32'(exp_g));
      chk($sformatf("alt%0d.gap", n), 32'(cyc), 1);
      tick();
      chk($sformatf("alt%0d.wrt1", n), 32'(wrt_SPI), 1);
      tick();
      chk($sformatf("alt%0d.wrt0", n), 32'(wrt_SPI), 0);
      SPI_done = 1'b1;
      EEP_data = 8'(8'h10 + n);
      tick();
      SPI_done = 1'b0;
      if (n == 3) req = '0;
      chk($sformatf("alt%0d.done", n), 32'(done), 32'(exp_g));
      chk($sformatf("alt%0d.rdata", n), 32'(rdata), 32'(8'h10 + n));
      chk($sformatf("alt%0d.gnt_off", n), 32'(gnt), 0);
      chk($sformatf("alt%0d.idle", n), 32'(busy), 0);
      exp_g = ~exp_g;
    end
    tick();

    // SPI_done in IDLE and in LAUNCH must be ignored.
    SPI_done = 1'b1;
    tick();
    SPI_done = 1'b0;
    chk("ign_idle.done", 32'(done), 0);
    chk("ign_idle.busy", 32'(busy), 0);
    req_ss   = {SS_TRIG, SS_CH2};
    req_data = {16'h0000, 16'hC0DE};
    req      = 2'b01;
    tick();
    chk("ign_l.gnt", 32'(gnt), 1);
    SPI_done = 1'b1;
    tick();
    SPI_done = 1'b0;
    chk("ign_l.done", 32'(done), 0);
    chk("ign_l.wrt", 32'(wrt_SPI), 1);
    tick();
    tick();
    chk("ign_l.hold_gnt", 32'(gnt), 1);
    chk("ign_l.hold_busy", 32'(busy), 1);
    chk("ign_l.hold_done", 32'(done), 0);
    SPI_done = 1'b1;
    EEP_data = 8'hA5;
    tick();
    SPI_done = 1'b0;
    req      = '0;
    chk("ign_l.done_end", 32'(done), 1);
    chk("ign_l.rdata", 32'(rdata), 32'h A5);
    tick();

    // Watchdog: no SPI_done, abort TIMEOUT+1 clocks after the wrt_SPI clock.
    req_data = {16'h0000, 16'hDEAD};
    req      = 2'b01;
    tick();
    chk("tmo.gnt", 32'(gnt), 1);
    tick();
    chk("tmo.wrt", 32'(wrt_SPI), 1);
    cyc = 0;
    while (done == 2'b00 && cyc < TMO + 10) begin
      tick();
      cyc++;
    end
    req = '0;
    chk("tmo.cycles", 32'(cyc), 32'(TMO + 1));
    chk("tmo.done", 32'(done), 1);
    chk("tmo.rdata", 32'(rdata), 32'h FF);
    chk("tmo.err", 32'(timeout_err), 1);
    chk("tmo.gnt_off", 32'(gnt), 0);
    tick();
    tick();
    chk("tmo.sticky", 32'(timeout_err), 1);
    run_vec(vt[5], "post_tmo");
    chk("tmo.sticky2", 32'(timeout_err), 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("tmo.cleared", 32'(timeout_err), 0);

    // Asynchronous reset during WAIT.
    req_data = {16'h0000, 16'h1111};
    req      = 2'b01;
    tick();
    tick();
    req = '0;
    tick();
    chk("rstw.busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw.gnt", 32'(gnt), 0);
    chk("rstw.busy", 32'(busy), 0);
    chk("rstw.wrt", 32'(wrt_SPI), 0);
    chk("rstw.data", 32'(SPI_data), 0);
    tick();
    chk("rstw.done", 32'(done), 0);
    rst_n = 1'b1;
    tick();
    chk("rstw.done2", 32'(done), 0);
    req_ss   = {SS_CH1, SS_CH3};
    req_data = {16'h2222, 16'h3333};
    req      = 2'b11;
    tick();
    chk("rstw.first", 32'(gnt), 1);
    tick();
    SPI_done = 1'b1;
    EEP_data = 8'h66;
    tick();
    SPI_done = 1'b0;
    req      = '0;
    chk("rstw.fin", 32'(done), 1);
    tick();

    // req dropped while waiting still completes to the same requester.
    req_ss   = {SS_CH3, SS_TRIG};
    req_data = {16'h9999, 16'h0000};
    req      = 2'b10;
    tick();
    chk("drop.gnt", 32'(gnt), 2);
    tick();
    req = '0;
    tick();
    tick();
    chk("drop.hold", 32'(gnt), 2);
    SPI_done = 1'b1;
    EEP_data = 8'h42;
    tick();
    SPI_done = 1'b0;
    chk("drop.done", 32'(done), 2);
    chk("drop.rdata", 32'(rdata), 32'h42);
    tick();
    chk("drop.idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
